// File: rtl/risc_pkg.sv
// Shared definitions for the fetch path: word width, fetch FSM encoding
// and the default reset PC.
package risc_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port. The fetch unit is the master: it raises
// imem_req with imem_addr and waits for imem_ack with imem_data.
interface fetch_unit_if;
  import risc_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter register: synchronous load or increment, async reset.
// A load wins over an increment in the same cycle.
module pc_counter
  import risc_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  inc,
  input  word_t load_value,
  output word_t pc
);

  // PC update: reset, then redirect, then sequential advance (wraps at 2^16)
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Holds a request at the current PC until the
// memory acknowledges, hands the word to decode with its address and the
// sequential next PC, freezes while decode stalls, and redirects on taken
// branches. A branch that interrupts an outstanding request parks in
// DISCARD so the late ack for the old address is swallowed.
module fetch_unit
  import risc_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  fetch_unit_if.master imem,
  input  logic  branch_taken,
  input  word_t branch_target,
  input  logic  stall,
  output word_t instr,
  output word_t instr_pc,
  output word_t pc_plus1,
  output logic  instr_valid
);

  fetch_state_t state, state_next;
  word_t        pc;
  word_t        discard_addr;
  logic         req;
  logic         capture;
  logic         pc_load;
  logic         pc_inc;
  logic         to_discard;

  pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .inc        (pc_inc),
    .load_value (branch_target),
    .pc         (pc)
  );

  // While draining a cancelled request the bus must keep the old address;
  // everywhere else the request address is the live PC.
  assign imem.imem_req  = req;
  assign imem.imem_addr = (state == DISCARD) ? discard_addr : pc;

  // Next-state and control decode; branch outranks both ack and stall
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    capture    = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    to_discard = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
        pc_load    = branch_taken;
      end
      FETCH: begin
        // No new request while a valid word is still waiting on decode.
        req = !(instr_valid && stall);
        if (branch_taken) begin
          pc_load = 1'b1;
          if (req && !imem.imem_ack) begin
            state_next = DISCARD;
            to_discard = 1'b1;
          end
        end else if (req && imem.imem_ack) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
        end else if (instr_valid && stall) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end else if (!stall) begin
          state_next = FETCH;
        end
      end
      DISCARD: begin
        req     = 1'b1;
        pc_load = branch_taken;
        if (imem.imem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember the address of the request being cancelled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_addr <= RESET_PC;
    end else if (to_discard) begin
      discard_addr <= pc;
    end
  end

  // Decode-facing output register: load on capture, clear on consume/redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      pc_plus1    <= '0;
      instr_valid <= 1'b0;
    end else if (capture) begin
      instr       <= imem.imem_data;
      instr_pc    <= pc;
      pc_plus1    <= pc + 16'd1;
      instr_valid <= 1'b1;
    end else if (branch_taken || !stall) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, a reset
// sequence, then randomized traffic against a transaction-level model.
module tb_fetch_unit;
  import risc_pkg::*;

  localparam word_t RST_PC = 16'h0000;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  branch_taken = 1'b0;
  word_t branch_target = '0;
  logic  stall = 1'b0;
  word_t instr, instr_pc, pc_plus1;
  logic  instr_valid;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_plus1      (pc_plus1),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic word_t mem_word(input word_t a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what decode should see and what the bus should show.
  logic  m_started;   // one idle cycle after reset has elapsed
  word_t m_pc;        // next address to fetch
  logic  m_owed;      // a cancelled request is still waiting for its ack
  word_t m_owed_addr;
  logic  m_frozen;    // last cycle was a stall with a word held
  logic  m_valid;
  word_t m_instr, m_ipc, m_pp1;

  task automatic model_reset();
    m_started = 1'b0; m_pc = RST_PC; m_owed = 1'b0; m_owed_addr = '0;
    m_frozen = 1'b0; m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_pp1 = '0;
  endtask

  function automatic logic model_req(input logic st);
    return m_started && (m_owed || (!m_frozen && !(m_valid && st)));
  endfunction

  task automatic model_update(input logic br, input word_t tgt, input logic st, input logic ack);
    logic req_now;
    req_now = model_req(st);
    if (!m_started) begin
      m_started = 1'b1;
      if (br) m_pc = tgt;
    end else if (m_owed) begin
      if (br) m_pc = tgt;
      if (ack) m_owed = 1'b0;
    end else if (br) begin
      if (req_now && !ack) begin
        m_owed = 1'b1;
        m_owed_addr = m_pc;
      end
      m_pc = tgt; m_valid = 1'b0; m_frozen = 1'b0;
    end else if (req_now && ack) begin
      m_instr = mem_word(m_pc); m_ipc = m_pc; m_pp1 = m_pc + 16'd1;
      m_valid = 1'b1; m_pc = m_pc + 16'd1; m_frozen = 1'b0;
    end else if (m_valid && st) begin
      m_frozen = 1'b1;
    end else begin
      if (!st) m_valid = 1'b0;
      m_frozen = 1'b0;
    end
  endtask

  logic  obs_req;
  word_t obs_addr;

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic step(input logic br, input word_t tgt, input logic st, input logic ack);
    logic e_req;
    branch_taken = br; branch_target = tgt; stall = st;
    #1;
    obs_req = imem.imem_req; obs_addr = imem.imem_addr;
    e_req = model_req(st);
    check("imem_req", obs_req, e_req);
    if (e_req) check("imem_addr", obs_addr, m_owed ? m_owed_addr : m_pc);
    imem.imem_ack  = ack;
    imem.imem_data = ack ? mem_word(obs_addr) : 16'hDEAD;
    @(posedge clk); #1;
    model_update(br, tgt, st, ack);
    check("instr_valid", instr_valid, m_valid);
    if (m_valid) begin
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
      check("pc_plus1", pc_plus1, m_pp1);
    end
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_imem_req", imem.imem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    check("rst_pc_plus1", pc_plus1, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic  br;
    word_t tgt;
    logic  st;
    logic  ack;
    logic  e_req;
    word_t e_addr;
    logic  e_valid;
    word_t e_ipc;
    word_t e_pp1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic br, input word_t tgt, input logic st, input logic ack,
                             input logic e_req, input word_t e_addr, input logic e_valid,
                             input word_t e_ipc, input word_t e_pp1);
    vec_t r;
    r.br = br; r.tgt = tgt; r.st = st; r.ack = ack; r.e_req = e_req; r.e_addr = e_addr;
    r.e_valid = e_valid; r.e_ipc = e_ipc; r.e_pp1 = e_pp1;
    return r;
  endfunction

  initial begin
    imem.imem_ack  = 1'b0;
    imem.imem_data = '0;
    model_reset();

    //              br  tgt       st  ack  req addr      vld ipc       pc+1
    tbl.push_back(v(0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000)); // idle cycle
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0000, 1, 16'h0000, 16'h0001));
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0001, 1, 16'h0001, 16'h0002));
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0002, 1, 16'h0002, 16'h0003));
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0003, 1, 16'h0003, 16'h0004));
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0004, 1, 16'h0004, 16'h0005));
    tbl.push_back(v(0, 16'h0000, 1, 1,   0, 16'h0000, 1, 16'h0004, 16'h0005)); // stall 1, stray ack
    tbl.push_back(v(0, 16'h0000, 1, 0,   0, 16'h0000, 1, 16'h0004, 16'h0005)); // stall 2
    tbl.push_back(v(0, 16'h0000, 1, 0,   0, 16'h0000, 1, 16'h0004, 16'h0005)); // stall 3
    tbl.push_back(v(0, 16'h0000, 0, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000)); // consumed
    tbl.push_back(v(0, 16'h0000, 0, 0,   1, 16'h0005, 0, 16'h0000, 16'h0000)); // fetch resumes
    tbl.push_back(v(1, 16'h0040, 0, 0,   1, 16'h0005, 0, 16'h0000, 16'h0000)); // cancel 0005
    tbl.push_back(v(0, 16'h0000, 0, 0,   1, 16'h0005, 0, 16'h0000, 16'h0000));
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0005, 0, 16'h0000, 16'h0000)); // late ack dropped
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0040, 1, 16'h0040, 16'h0041));
    tbl.push_back(v(1, 16'h0100, 1, 1,   0, 16'h0000, 0, 16'h0000, 16'h0000)); // br+stall+ack, held word
    tbl.push_back(v(1, 16'hFFFE, 1, 1,   1, 16'h0100, 0, 16'h0000, 16'h0000)); // br+stall+ack, live req
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'hFFFE, 1, 16'hFFFE, 16'hFFFF));
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'hFFFF, 1, 16'hFFFF, 16'h0000)); // wrap
    tbl.push_back(v(0, 16'h0000, 0, 1,   1, 16'h0000, 1, 16'h0000, 16'h0001));

    @(posedge clk); #1;
    pulse_reset();

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].br, tbl[i].tgt, tbl[i].st, tbl[i].ack);
      check($sformatf("tbl%0d_req", i), obs_req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_ipc", i), instr_pc, tbl[i].e_ipc);
        check($sformatf("tbl%0d_pp1", i), pc_plus1, tbl[i].e_pp1);
      end
    end

    // Reset mid-fetch, then a stray ack during the idle cycle
    step(0, 16'h0000, 0, 0);
    pulse_reset();
    step(0, 16'h0000, 0, 1);
    check("post_rst_stray_valid", instr_valid, 1'b0);
    step(0, 16'h0000, 0, 1);
    check("post_rst_first_pc", instr_pc, RST_PC);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        logic  br, st, ack;
        word_t tgt;
        br  = ($urandom_range(0, 9) == 0);
        st  = ($urandom_range(0, 2) == 0);
        ack = ($urandom_range(0, 1) == 1);
        tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFE : word_t'($urandom);
        step(br, tgt, st, ack);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 16 bits: read address, equal to the current PC.
REQ-006 SHALL have port imem_ack, input, 1 bit: read data valid this cycle.
REQ-007 SHALL have port imem_data, input, 16 bits: instruction word, sampled only when imem_ack=1.
REQ-008 SHALL have port branch_taken, input, 1 bit: redirect request from execute.
REQ-009 SHALL have port branch_target, input, 16 bits: redirect address.
REQ-010 SHALL have port stall, input, 1 bit: decode cannot accept a new instruction.
REQ-011 SHALL have port instr, output, 16 bits: fetched instruction to decode.
REQ-012 SHALL have port instr_pc, output, 16 bits: address of instr.
REQ-013 SHALL have port pc_plus1, output, 16 bits: instr_pc+1 mod 2^16, the sequential next-PC candidate.
REQ-014 SHALL have port instr_valid, output, 1 bit: instr/instr_pc/pc_plus1 are meaningful.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HOLD, DISCARD.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then move to FETCH.
REQ-017 In FETCH, SHALL hold imem_req=1 with imem_addr=PC stable until imem_ack=1.
REQ-018 On imem_ack in FETCH with no branch_taken: SHALL register instr=imem_data, instr_pc=PC, pc_plus1=PC+1, set instr_valid=1 the next cycle, and increment PC (16'hFFFF wraps to 16'h0000).
REQ-019 After a capture with stall=0, SHALL remain in FETCH and issue the next request the following cycle, giving 1 instruction per cycle at zero-wait memory.
REQ-020 If instr_valid=1 and stall=1, SHALL enter HOLD: imem_req=0, all outputs frozen; SHALL return to FETCH on the first cycle with stall=0.
REQ-021 SHALL clear instr_valid when decode consumes (stall=0) and no new capture occurs that cycle.
REQ-022 On branch_taken=1 in IDLE, HOLD, or FETCH without an outstanding request: SHALL load PC=branch_target, drop instr_valid next cycle, and enter FETCH.
REQ-023 On branch_taken=1 in FETCH with a request outstanding and no ack: SHALL load PC=branch_target, enter DISCARD, and keep imem_req/imem_addr unchanged until ack.
REQ-024 In DISCARD, SHALL drop the acked data, keep instr_valid=0, and return to FETCH at the new PC.
REQ-025 branch_taken coincident with imem_ack SHALL discard the ack data and load PC=branch_target, with no DISCARD visit.
REQ-026 branch_taken SHALL take priority over stall in the same cycle.
REQ-027 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-028 rst=1 SHALL immediately force PC=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=16'h0000, instr_pc=16'h0000, pc_plus1=16'h0000, regardless of clk.
REQ-029 Reset asserted mid-request SHALL abandon the request; a later ack SHALL be ignored per REQ-027.

Structure
REQ-030 Shared package risc_pkg SHALL hold WORD_W=16, the FSM state encoding, and the default RESET_PC.
REQ-031 SHALL instantiate one sub-module, pc_counter: a 16-bit register with load, increment, and async reset.

Verification
REQ-032 Reset release, ack every cycle, stall=0 -> instr_pc = 0000, 0001, 0002, ...; instr_valid=1 from the cycle after the first ack.
REQ-033 PC=FFFF with ack -> instr_pc=FFFF, pc_plus1=0000, next imem_addr=0000.
REQ-034 stall=1 for 3 cycles with instr_valid=1 -> imem_req=0 and outputs frozen for 3 cycles; fetch resumes the cycle after stall drops.
REQ-035 branch_taken with target 0x0040 while a request for 0x0005 is outstanding, ack 2 cycles later -> data for 0x0005 never valid; next imem_addr=0x0040.
REQ-036 branch_taken, stall, and imem_ack in the same cycle -> ack data dropped, PC=target, instr_valid=0 next cycle.
REQ-037 rst pulsed mid-fetch between clock edges -> imem_req=0 and instr_valid=0 immediately; a later stray ack produces no output.
